irs_readout_scheduler: RTL and testbench

Sequences one event readout through the IRS DMA engine's 3-bit register port.
- Accepts a readout request with per-daughter block counts.
- Waits until the event FIFO has room for the whole event.
- Programs each daughter's DMA count, starts the DMA, then watches the DMA active flag until it drops.
- Reports done or timeout to the event builder; on timeout it pulses a DMA reset.

---
 rtl/irs_readout_pkg.sv | 27 ++
 rtl/irs_readout_watchdog.sv | 27 ++
 rtl/irs_readout_scheduler.sv | 159 +++++++++++++++
 tb/tb_irs_readout_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irs_readout_pkg.sv
// Shared definitions for the IRS readout scheduler: FSM encoding, DMA register
// map constants and the per-daughter word-count helper.
package irs_readout_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SUM,
      ST_WAIT_SPACE,
      ST_PROG,
      ST_START,
      ST_WAIT_ACT,
      ST_RUN,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [2:0] DMA_CSR_ADDR  = 3'b100;
   localparam int         DMA_START_BIT = 0;
   localparam int         WORD_SHIFT    = 6;
   localparam int         TOTAL_BITS    = 13;

   // A daughter with count n moves n*64 data words plus one header word.
   function automatic logic [TOTAL_BITS-1:0] daughter_words(input logic [3:0] len);
      return (TOTAL_BITS'(len) << WORD_SHIFT) + TOTAL_BITS'(1);
   endfunction

endpackage

// File: rtl/irs_readout_watchdog.sv
// Loadable up-counter with an all-ones terminal-count flag; used both as the
// start-acknowledge timer and as the run watchdog.
module irs_readout_watchdog #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   output logic             tc
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         count_reg <= '0;
      else if (load)
         count_reg <= load_val;
      else if (enable)
         count_reg <= count_reg + 1'b1;
   end

   assign tc = &count_reg;

endmodule

// File: rtl/irs_readout_scheduler.sv
// Sequences one event readout: latch lengths, wait for FIFO room, program the
// DMA counts, start it, and supervise the active flag with a watchdog.
module irs_readout_scheduler
   import irs_readout_pkg::*;
#(
   parameter int MAX_DAUGHTERS = 4,
   parameter int NUM_DAUGHTERS = 4,
   parameter int TIMEOUT_BITS  = 16,
   parameter int START_WAIT    = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_i,
   input  logic [4*MAX_DAUGHTERS-1:0] len_i,
   output logic                       ack_o,
   input  logic [15:0]                fifo_free_i,
   output logic [2:0]                 dma_addr_o,
   output logic [7:0]                 dma_dat_o,
   output logic                       dma_wr_o,
   input  logic                       dma_active_i,
   output logic                       dma_rst_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       error_o,
   input  logic                       err_clr_i
);

   localparam int AW = (MAX_DAUGHTERS > 1) ? $clog2(MAX_DAUGHTERS) : 1;
   localparam logic [AW-1:0] LAST_DAU = AW'(NUM_DAUGHTERS - 1);
   // Preload so the terminal count lands on the START_WAIT-th WAIT_ACT cycle.
   localparam logic [TIMEOUT_BITS-1:0] START_LOAD = TIMEOUT_BITS'((1 << TIMEOUT_BITS) - START_WAIT);

   state_t                  state_reg, state_next;
   logic [3:0]              len_reg [MAX_DAUGHTERS];
   logic [TOTAL_BITS-1:0]   total_reg, total_next;
   logic [AW-1:0]           dau_reg, dau_next;
   logic                    err_seen_reg;
   logic                    wd_load, wd_en, wd_tc;
   logic [TIMEOUT_BITS-1:0] wd_load_val;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         total_reg    <= '0;
         dau_reg      <= '0;
         err_seen_reg <= 1'b0;
         for (int d = 0; d < MAX_DAUGHTERS; d++)
            len_reg[d] <= '0;
      end else begin
         state_reg    <= state_next;
         dau_reg      <= dau_next;
         err_seen_reg <= (state_reg == ST_ERR);
         if (state_reg == ST_SUM)
            total_reg <= total_next;
         if (state_reg == ST_IDLE && req_i) begin
            for (int d = 0; d < MAX_DAUGHTERS; d++)
               len_reg[d] <= len_i[4*d +: 4];
         end
      end
   end

   always_comb begin
      total_next = '0;
      for (int d = 0; d < NUM_DAUGHTERS; d++)
         total_next = total_next + daughter_words(len_reg[d]);
   end

   always_comb begin
      state_next  = state_reg;
      dau_next    = dau_reg;
      wd_load     = 1'b0;
      wd_load_val = '0;
      wd_en       = 1'b0;
      ack_o       = 1'b0;
      dma_addr_o  = '0;
      dma_dat_o   = '0;
      dma_wr_o    = 1'b0;
      dma_rst_o   = 1'b0;
      busy_o      = (state_reg != ST_IDLE);
      done_o      = 1'b0;
      error_o     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req_i)
               state_next = ST_SUM;
         end
         ST_SUM: begin
            ack_o      = 1'b1;
            dau_next   = '0;
            state_next = ST_WAIT_SPACE;
         end
         ST_WAIT_SPACE: begin
            if (fifo_free_i >= 16'(total_reg))
               state_next = ST_PROG;
         end
         ST_PROG: begin
            dma_wr_o   = 1'b1;
            dma_addr_o = 3'(dau_reg);
            dma_dat_o  = {4'b0, len_reg[dau_reg]};
            if (dau_reg == LAST_DAU)
               state_next = ST_START;
            else
               dau_next = dau_reg + 1'b1;
         end
         ST_START: begin
            dma_wr_o    = 1'b1;
            dma_addr_o  = DMA_CSR_ADDR;
            dma_dat_o   = 8'(1 << DMA_START_BIT);
            wd_load     = 1'b1;
            wd_load_val = START_LOAD;
            state_next  = ST_WAIT_ACT;
         end
         ST_WAIT_ACT: begin
            if (dma_active_i) begin
               // Count the first RUN cycle so the terminal count is hit on cycle 2^N-1.
               wd_load     = 1'b1;
               wd_load_val = TIMEOUT_BITS'(1);
               state_next  = ST_RUN;
            end else begin
               wd_en = 1'b1;
               if (wd_tc)
                  state_next = ST_ERR;
            end
         end
         ST_RUN: begin
            wd_en = 1'b1;
            if (!dma_active_i)
               state_next = ST_DONE;
            else if (wd_tc)
               state_next = ST_ERR;
         end
         ST_DONE: begin
            done_o     = 1'b1;
            wd_load    = 1'b1;
            state_next = ST_IDLE;
         end
         ST_ERR: begin
            error_o   = 1'b1;
            dma_rst_o = !err_seen_reg;
            wd_load   = 1'b1;
            if (err_clr_i)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   irs_readout_watchdog #(
      .WIDTH(TIMEOUT_BITS)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load    (wd_load),
      .load_val(wd_load_val),
      .enable  (wd_en),
      .tc      (wd_tc)
   );

endmodule

// File: tb/tb_irs_readout_scheduler.sv
// Scoreboard bench: expected DMA writes are queued per request and matched by a
// write monitor; scenario tasks check handshake, gating and timeout timing.
module tb_irs_readout_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [15:0] len = '0;
   logic [15:0] fifo_free = '0;
   logic        dma_active = 1'b0;
   logic        err_clr = 1'b0;

   logic       ack, wr, dma_rst, busy, done, error;
   logic [2:0] addr;
   logic [7:0] dat;
   logic       ack4, wr4, dma_rst4, busy4, done4, error4;
   logic [2:0] addr4;
   logic [7:0] dat4;

   int n_checks = 0;
   int n_fail   = 0;
   logic [10:0] sb_q[$];

   always #5 clk = ~clk;

   irs_readout_scheduler dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .len_i(len), .ack_o(ack),
      .fifo_free_i(fifo_free), .dma_addr_o(addr), .dma_dat_o(dat), .dma_wr_o(wr),
      .dma_active_i(dma_active), .dma_rst_o(dma_rst), .busy_o(busy), .done_o(done),
      .error_o(error), .err_clr_i(err_clr)
   );

   // Short watchdog instance for the run-timeout scenarios; shares all inputs.
   irs_readout_scheduler #(.TIMEOUT_BITS(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .len_i(len), .ack_o(ack4),
      .fifo_free_i(fifo_free), .dma_addr_o(addr4), .dma_dat_o(dat4), .dma_wr_o(wr4),
      .dma_active_i(dma_active), .dma_rst_o(dma_rst4), .busy_o(busy4), .done_o(done4),
      .error_o(error4), .err_clr_i(err_clr)
   );

   always @(negedge clk) begin
      if (wr === 1'b1) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL dma_write: unexpected write addr=%0d dat=%h, none expected", addr, dat);
         end else begin
            logic [10:0] exp_w;
            exp_w = sb_q.pop_front();
            if ({addr, dat} !== exp_w) begin
               n_fail++;
               $display("FAIL dma_write: got addr=%0d dat=%h, expected addr=%0d dat=%h",
                        addr, dat, exp_w[10:8], exp_w[7:0]);
            end else
               $display("write addr=%0d dat=%h", addr, dat);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 1'b0; err_clr = 1'b0; dma_active = 1'b0;
      tick(); tick();
      rst = 1'b0;
      sb_q.delete();
   endtask

   task automatic issue_req(input logic [15:0] l);
      req = 1'b1;
      len = l;
      for (int d = 0; d < 4; d++)
         sb_q.push_back({3'(d), 4'b0, l[4*d +: 4]});
      sb_q.push_back({3'b100, 8'h01});
      tick();
      req = 1'b0;
   endtask

   task automatic wait_start(output int ok);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (wr === 1'b1 && addr === 3'b100) begin
            ok = 1;
            return;
         end
         tick();
      end
      n_checks++; n_fail++;
      $display("FAIL wait_start: no start write within 200 cycles");
   endtask

   task automatic finish_done(input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
         tick();
         if (done === 1'b1) seen = 1;
      end
      n_checks++;
      if (seen == 0) begin
         n_fail++;
         $display("FAIL %s_done: done_o not seen, required 1", name);
      end
      tick();
      n_checks++;
      if ({busy, error, done} !== 3'b000) begin
         n_fail++;
         $display("FAIL %s_idle: busy/error/done=%b required 000", name, {busy, error, done});
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_writes: %0d expected writes missing, required 0", name, sb_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({ack, wr, addr, dat, dma_rst, busy, done, error} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0000",
                  {ack, wr, addr, dat, dma_rst, busy, done, error});
      end
   endtask

   task automatic test_nominal();
      int ok, saw_wr;
      do_reset();
      fifo_free = 16'd643;            // one short of the 644-word event
      issue_req(16'h4321);
      n_checks++;
      if (ack !== 1'b1) begin n_fail++; $display("FAIL nominal_ack: got %b required 1", ack); end
      saw_wr = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wr === 1'b1) saw_wr = 1;
      end
      n_checks++;
      if (saw_wr != 0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL nominal_gate643: wr_seen=%0d busy=%b required 0/1", saw_wr, busy);
      end
      fifo_free = 16'd1000;
      tick();
      n_checks++;
      if (!(wr === 1'b1 && addr === 3'd0)) begin
         n_fail++;
         $display("FAIL nominal_first_write: wr=%b addr=%0d required 1/0", wr, addr);
      end
      wait_start(ok);
      if (ok == 0) return;
      tick(); tick();
      dma_active = 1'b1;
      repeat (650) tick();
      dma_active = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL nominal_run_busy: done=%b busy=%b required 0/1", done, busy);
      end
      tick();
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL nominal_done_latency: got %b required 1", done); end
      tick();
      n_checks++;
      if ({done, busy, error} !== 3'b000) begin
         n_fail++;
         $display("FAIL nominal_idle: done/busy/error=%b required 000", {done, busy, error});
      end
      n_checks++;
      if (sb_q.size() != 0) begin n_fail++; $display("FAIL nominal_writes: %0d left required 0", sb_q.size()); end
   endtask

   task automatic test_space_gating();
      int ok, saw_wr;
      do_reset();
      fifo_free = 16'd3843;
      issue_req(16'hFFFF);
      saw_wr = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (wr === 1'b1) saw_wr = 1;
      end
      n_checks++;
      if (saw_wr != 0) begin n_fail++; $display("FAIL gate_3843: write seen=%0d required 0", saw_wr); end
      fifo_free = 16'd3844;
      tick();
      n_checks++;
      if (!(wr === 1'b1 && addr === 3'd0 && dat === 8'h0F)) begin
         n_fail++;
         $display("FAIL gate_3844: wr=%b addr=%0d dat=%h required 1/0/0f", wr, addr, dat);
      end
      wait_start(ok);
      if (ok == 0) return;
      tick(); tick();
      dma_active = 1'b1;
      repeat (20) tick();
      dma_active = 1'b0;
      finish_done("gate");
   endtask

   task automatic test_zero_len();
      int ok;
      do_reset();
      fifo_free = 16'd4;              // exactly the 4-word total: inclusive compare
      issue_req(16'h0000);
      tick();
      n_checks++;
      if (wr !== 1'b0) begin n_fail++; $display("FAIL zero_latency_early: wr=%b required 0", wr); end
      tick();
      n_checks++;
      if (!(wr === 1'b1 && addr === 3'd0 && dat === 8'h00)) begin
         n_fail++;
         $display("FAIL zero_latency: wr=%b addr=%0d dat=%h required 1/0/00", wr, addr, dat);
      end
      wait_start(ok);
      if (ok == 0) return;
      tick(); tick();
      dma_active = 1'b1;
      repeat (5) tick();
      dma_active = 1'b0;
      finish_done("zero");
   endtask

   task automatic test_start_timeout();
      int ok, early;
      do_reset();
      fifo_free = 16'd1000;
      issue_req(16'h1111);
      wait_start(ok);
      if (ok == 0) return;
      // Active never rises: START_WAIT cycles of waiting, then ERR.
      early = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (dma_rst === 1'b1 || error === 1'b1) early = 1;
      end
      n_checks++;
      if (early != 0) begin n_fail++; $display("FAIL start_to_early: error seen=%0d required 0", early); end
      tick();
      n_checks++;
      if ({dma_rst, error} !== 2'b11) begin
         n_fail++;
         $display("FAIL start_to_err: dma_rst/error=%b required 11", {dma_rst, error});
      end
      tick();
      n_checks++;
      if ({dma_rst, error, busy} !== 3'b011) begin
         n_fail++;
         $display("FAIL start_to_sticky: dma_rst/error/busy=%b required 011", {dma_rst, error, busy});
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if ({busy, error} !== 2'b00) begin
         n_fail++;
         $display("FAIL start_to_clear: busy/error=%b required 00", {busy, error});
      end
   endtask

   task automatic test_run_timeout();
      int ok, early;
      do_reset();
      fifo_free = 16'd1000;
      issue_req(16'h2222);
      wait_start(ok);
      if (ok == 0) return;
      tick(); tick();
      dma_active = 1'b1;
      early = 0;
      for (int k = 0; k <= 14; k++) begin
         tick();
         if (dma_rst4 === 1'b1 || error4 === 1'b1) early = 1;
      end
      n_checks++;
      if (early != 0 || busy4 !== 1'b1) begin
         n_fail++;
         $display("FAIL run_to_early: error seen=%0d busy=%b required 0/1", early, busy4);
      end
      tick();
      n_checks++;
      if ({dma_rst4, error4} !== 2'b11) begin
         n_fail++;
         $display("FAIL run_to_err: dma_rst/error=%b required 11", {dma_rst4, error4});
      end
      dma_active = 1'b0;
      finish_done("run_to_wide");
   endtask

   task automatic test_run_tc_done();
      int ok;
      do_reset();
      fifo_free = 16'd1000;
      issue_req(16'h3333);
      wait_start(ok);
      if (ok == 0) return;
      tick(); tick();
      dma_active = 1'b1;
      for (int k = 0; k <= 13; k++) tick();
      tick();
      dma_active = 1'b0;              // falls on the terminal-count cycle
      tick();
      n_checks++;
      if ({done4, error4, dma_rst4} !== 3'b100) begin
         n_fail++;
         $display("FAIL run_tc_done: done/error/dma_rst=%b required 100", {done4, error4, dma_rst4});
      end
      tick();
      n_checks++;
      if ({busy4, error4} !== 2'b00) begin
         n_fail++;
         $display("FAIL run_tc_idle: busy/error=%b required 00", {busy4, error4});
      end
      sb_q.delete();
   endtask

   task automatic test_reset_mid_prog();
      int found;
      do_reset();
      fifo_free = 16'd1000;
      issue_req(16'h4321);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick();
         if (sb_q.size() == 3) found = 1;
      end
      n_checks++;
      if (found == 0) begin n_fail++; $display("FAIL midprog_second_write: not seen, required seen"); end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({ack, wr, addr, dat, dma_rst, busy, done, error} !== 16'h0) begin
         n_fail++;
         $display("FAIL midprog_outputs: got %h required 0000",
                  {ack, wr, addr, dat, dma_rst, busy, done, error});
      end
      rst = 1'b0;
      sb_q.delete();
      repeat (8) tick();              // the monitor flags any stray write here
      issue_req(16'h0005);
      n_checks++;
      if (ack !== 1'b1) begin n_fail++; $display("FAIL midprog_reack: got %b required 1", ack); end
      begin
         int ok;
         wait_start(ok);
         if (ok == 0) return;
      end
      tick(); tick();
      dma_active = 1'b1;
      repeat (3) tick();
      dma_active = 1'b0;
      finish_done("midprog");
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_space_gating();
      test_zero_len();
      test_start_timeout();
      test_run_timeout();
      test_run_tc_done();
      test_reset_mid_prog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
